// File: rtl/ahb_slave_regif_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and the register-interface slave.
// The master modport also drives the bus-level hready that the interconnect returns.
interface ahb_slave_regif_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_regif.sv
// AHB-Lite register slave for the AHB-to-I2C bridge: TX FIFO push, RX pop, CTRL and STATUS.
// Optional wait-state timeout when AHB_WAIT_TIMEOUT_EN is defined.
//
// state    | meaning
// DP_IDLE  | no data phase pending, zero-wait OKAY
// DP_WR    | write data phase, stalls while the TX FIFO is full
// DP_RD    | read data phase, stalls while no RX word is available
// DP_ERR1  | first ERROR cycle (hreadyout low)
// DP_ERR2  | second ERROR cycle (hreadyout high)
module ahb_slave_regif #(
  parameter int          TXF_DEPTH = 4,
  parameter logic [31:0] CTRL_RST  = 32'h0000_0000,
  parameter int          MAX_WAIT  = 16
) (
  input  logic                Hclk,
  input  logic                Hreset,
  ahb_slave_regif_if.slave    bus,
  output logic                tx_valid,
  output logic [31:0]         tx_data,
  input  logic                tx_ready,
  input  logic                rx_valid,
  input  logic [31:0]         rx_data,
  output logic                rx_ready,
  output logic [31:0]         ctrl
);
  localparam int AW = (TXF_DEPTH > 1) ? $clog2(TXF_DEPTH) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(TXF_DEPTH);
  localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_CTRL = 2'd2, A_STAT = 2'd3;

  typedef enum logic [2:0] {DP_IDLE, DP_WR, DP_RD, DP_ERR1, DP_ERR2} dp_state_t;

  dp_state_t     state;
  logic [1:0]    reg_sel;
  logic [31:0]   tx_mem [TXF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   tx_level;
  logic [7:0]    level8;
  logic [31:0]   hrdata_q, rd_val;
  logic          ready, resp, push, pop, accept, dec_err, wait_expire;
  logic          unused_bus;

  assign unused_bus = ^{bus.hburst, bus.haddr[31:4]};
  assign level8     = {{(7-AW){1'b0}}, tx_level};
  assign tx_valid   = tx_level != '0;
  assign tx_data    = tx_valid ? tx_mem[rd_ptr] : '0;
  assign pop        = tx_valid & tx_ready;
  assign accept     = bus.hsel & bus.hready & bus.htrans[1];
  assign dec_err    = (bus.hsize != 3'b010) || (bus.haddr[1:0] != 2'b00) ||
                      (bus.hwrite ? (bus.haddr[3:2] == A_RX || bus.haddr[3:2] == A_STAT)
                                  : (bus.haddr[3:2] == A_TX));

  // A full FIFO still accepts the push when the head leaves in the same cycle.
  always_comb begin
    ready    = 1'b1;
    resp     = 1'b0;
    rx_ready = 1'b0;
    push     = 1'b0;
    rd_val   = '0;
    case (state)
      DP_WR: begin
        if (reg_sel == A_TX) begin
          ready = (tx_level != FULL_LVL) || pop;
          push  = ready;
        end
      end
      DP_RD: begin
        case (reg_sel)
          A_RX: begin
            ready    = rx_valid;
            rx_ready = rx_valid;
            rd_val   = rx_data;
          end
          A_CTRL:  rd_val = ctrl;
          A_STAT:  rd_val = {16'h0, rx_valid, 7'h0, level8};
          default: rd_val = '0;
        endcase
      end
      DP_ERR1: begin
        ready = 1'b0;
        resp  = 1'b1;
      end
      DP_ERR2: resp = 1'b1;
      default: ;
    endcase
  end

  assign bus.hreadyout = ready;
  assign bus.hresp     = resp;
  assign bus.hrdata    = (state == DP_RD && ready) ? rd_val : hrdata_q;

`ifdef AHB_WAIT_TIMEOUT_EN
  localparam int WCW = $clog2(MAX_WAIT + 1);
  logic [WCW-1:0] wait_cnt;

  assign wait_expire = (state == DP_WR || state == DP_RD) && !ready &&
                       (wait_cnt == WCW'(MAX_WAIT - 1));

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset)                                            wait_cnt <= '0;
    else if (ready || wait_expire)                         wait_cnt <= '0;
    else if (state == DP_WR || state == DP_RD)             wait_cnt <= wait_cnt + 1'b1;
  end
`else
  localparam int unused_max_wait = MAX_WAIT;
  assign wait_expire = 1'b0;
`endif

  always_ff @(posedge Hclk) begin
    if (push) tx_mem[wr_ptr] <= bus.hwdata;
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state    <= DP_IDLE;
      reg_sel  <= A_TX;
      ctrl     <= CTRL_RST;
      hrdata_q <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      tx_level <= tx_level + 1'b1;
      else if (!push && pop) tx_level <= tx_level - 1'b1;

      if (state == DP_WR && reg_sel == A_CTRL && ready) ctrl <= bus.hwdata;
      if (state == DP_RD && ready) hrdata_q <= rd_val;

      if (ready) begin
        if (accept) begin
          reg_sel <= bus.haddr[3:2];
          state   <= dec_err ? DP_ERR1 : (bus.hwrite ? DP_WR : DP_RD);
        end else begin
          state <= DP_IDLE;
        end
      end else if (state == DP_ERR1) begin
        state <= DP_ERR2;
      end else if (wait_expire) begin
        state <= DP_ERR1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_slave_regif.sv
// Self-checking bench for ahb_slave_regif: randomized transfers against a queue/variable model.
// Timeout expectations follow AHB_WAIT_TIMEOUT_EN as seen by this compile.
module tb_ahb_slave_regif;
  localparam int          TXF_DEPTH = 4;
  localparam logic [31:0] CTRL_RST  = 32'h0000_0000;
  localparam int          MAX_WAIT  = 16;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] tx_data, rx_data, ctrl;

  always #5 Hclk = ~Hclk;

  ahb_slave_regif_if bus();
  assign bus.hready = bus.hreadyout;

  ahb_slave_regif #(.TXF_DEPTH(TXF_DEPTH), .CTRL_RST(CTRL_RST), .MAX_WAIT(MAX_WAIT)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .bus(bus),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .ctrl(ctrl)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ctrl_m;
  logic [31:0] txq[$];

  task automatic bus_idle();
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = '0; bus.hwrite = 1'b0;
    bus.hsize = 3'b010; bus.hburst = 3'b000; bus.hwdata = '0;
  endtask

  // One transfer from address phase to completion; returns aligned 1 time unit after a rising edge.
  task automatic ahb_xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int waits,
                          output bit err_first, output bit resp_last, output bit timed_out);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = addr; bus.hwrite = wr; bus.hsize = size;
    @(posedge Hclk); #1;
    bus_idle();
    bus.hwdata = wdata;
    waits = 0; err_first = 1'b0; resp_last = 1'b0; timed_out = 1'b1; rdata = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge Hclk);
      if (c == 0) err_first = bus.hresp;
      if (bus.hreadyout) begin
        rdata = bus.hrdata; resp_last = bus.hresp; timed_out = 1'b0;
        break;
      end
      waits++;
      @(posedge Hclk); #1;
    end
    @(posedge Hclk); #1;
  endtask

  task automatic drain_check();
    tx_ready = 1'b1;
    for (int c = 0; c < 40 && txq.size() > 0; c++) begin
      @(negedge Hclk);
      total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL drain_valid: got %0b want 1", tx_valid); end
      total++; if (tx_data !== txq[0]) begin bad++; $display("FAIL drain_data: got %h want %h", tx_data, txq[0]); end
      @(posedge Hclk);
      void'(txq.pop_front());
      #1;
    end
    tx_ready = 1'b0;
    @(negedge Hclk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %0b want 0", tx_valid); end
    @(posedge Hclk); #1;
  endtask

  task automatic test_reset();
    Hreset = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    bus_idle();
    repeat (3) @(posedge Hclk);
    #1 Hreset = 1'b0;
    ctrl_m = CTRL_RST;
    @(negedge Hclk);
    total++; if (bus.hreadyout !== 1'b1) begin bad++; $display("FAIL rst_hreadyout: got %0b want 1", bus.hreadyout); end
    total++; if (bus.hresp !== 1'b0) begin bad++; $display("FAIL rst_hresp: got %0b want 0", bus.hresp); end
    total++; if (bus.hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata: got %h want 0", bus.hrdata); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rst_rx_ready: got %0b want 0", rx_ready); end
    total++; if (ctrl !== CTRL_RST) begin bad++; $display("FAIL rst_ctrl: got %h want %h", ctrl, CTRL_RST); end
    total++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin bad++; $display("FAIL rst_tx: got %0b/%h want 0/0", tx_valid, tx_data); end
    @(posedge Hclk); #1;
  endtask

  task automatic test_ctrl();
    logic [31:0] v, rd;
    int w; bit ef, rl, to;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 32'hA5A5_1234 : $urandom;
      ahb_xfer(32'h8, 1'b1, 3'b010, v, rd, w, ef, rl, to);
      ctrl_m = v;
      total++; if (to || w != 0 || rl) begin bad++; $display("FAIL ctrl_wr_resp: got to=%0b waits=%0d resp=%0b want 0/0/0", to, w, rl); end
      total++; if (ctrl !== ctrl_m) begin bad++; $display("FAIL ctrl_out: got %h want %h", ctrl, ctrl_m); end
      ahb_xfer(32'h8, 1'b0, 3'b010, $urandom, rd, w, ef, rl, to);
      total++; if (to || w != 0 || rl) begin bad++; $display("FAIL ctrl_rd_resp: got to=%0b waits=%0d resp=%0b want 0/0/0", to, w, rl); end
      total++; if (rd !== ctrl_m) begin bad++; $display("FAIL ctrl_rd_data: got %h want %h", rd, ctrl_m); end
      total++; if (bus.hrdata !== ctrl_m) begin bad++; $display("FAIL ctrl_rd_hold: got %h want %h", bus.hrdata, ctrl_m); end
    end
  endtask

  task automatic test_tx_fill();
    logic [31:0] words [4];
    logic [31:0] rd;
    int w; bit ef, rl, to;
    words = '{32'h11, 32'h22, 32'h33, 32'h44};
    tx_ready = 1'b0;
    for (int i = 0; i < TXF_DEPTH; i++) begin
      ahb_xfer(32'h0, 1'b1, 3'b010, words[i], rd, w, ef, rl, to);
      txq.push_back(words[i]);
      total++; if (to || w != 0 || rl) begin bad++; $display("FAIL fill_wr%0d: got to=%0b waits=%0d resp=%0b want 0/0/0", i, to, w, rl); end
    end
    ahb_xfer(32'hC, 1'b0, 3'b010, '0, rd, w, ef, rl, to);
    total++; if (rd !== 32'(txq.size())) begin bad++; $display("FAIL fill_status: got %h want %h", rd, 32'(txq.size())); end
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h0; bus.hwrite = 1'b1; bus.hsize = 3'b010;
    @(posedge Hclk); #1;
    bus_idle();
    bus.hwdata = 32'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge Hclk);
      total++; if (bus.hreadyout !== 1'b0) begin bad++; $display("FAIL full_stall: got %0b want 0", bus.hreadyout); end
      total++; if (tx_data !== txq[0]) begin bad++; $display("FAIL full_head: got %h want %h", tx_data, txq[0]); end
      @(posedge Hclk); #1;
    end
    tx_ready = 1'b1;
    @(negedge Hclk);
    total++; if (bus.hreadyout !== 1'b1) begin bad++; $display("FAIL full_release: got %0b want 1", bus.hreadyout); end
    @(posedge Hclk);
    void'(txq.pop_front());
    txq.push_back(32'h55);
    #1 tx_ready = 1'b0;
    ahb_xfer(32'hC, 1'b0, 3'b010, '0, rd, w, ef, rl, to);
    total++; if (rd !== 32'(txq.size())) begin bad++; $display("FAIL full_status2: got %h want %h", rd, 32'(txq.size())); end
    drain_check();
  endtask

  task automatic test_back_to_back();
    logic [31:0] wv [8];
    for (int i = 0; i < 8; i++) wv[i] = $urandom;
    tx_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        bus.hsel = 1'b1; bus.htrans = (i == 0) ? 2'b10 : 2'b11; bus.haddr = 32'h0;
        bus.hwrite = 1'b1; bus.hsize = 3'b010;
      end else begin
        bus.hsel = 1'b0; bus.htrans = 2'b00;
      end
      if (i > 0) bus.hwdata = wv[i-1];
      @(negedge Hclk);
      total++; if (bus.hreadyout !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %0b want 1", i, bus.hreadyout); end
      if (txq.size() > 0) begin
        total++; if (tx_data !== txq[0]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, tx_data, txq[0]); end
      end
      @(posedge Hclk);
      if (txq.size() > 0) void'(txq.pop_front());
      if (i > 0) txq.push_back(wv[i-1]);
      #1;
    end
    bus_idle();
    drain_check();
  endtask

  task automatic test_rx_wait();
    int wl [3];
    logic [31:0] val;
    wl = '{3, int'($urandom_range(0, 4)), int'($urandom_range(1, 6))};
    for (int t = 0; t < 3; t++) begin
      val = (t == 0) ? 32'hDEAD_BEEF : $urandom;
      rx_valid = 1'b0;
      bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h4; bus.hwrite = 1'b0; bus.hsize = 3'b010;
      @(posedge Hclk); #1;
      bus_idle();
      for (int c = 0; c <= wl[t]; c++) begin
        rx_valid = (c == wl[t]);
        rx_data  = (c == wl[t]) ? val : $urandom;
        @(negedge Hclk);
        if (c < wl[t]) begin
          total++; if (bus.hreadyout !== 1'b0 || rx_ready !== 1'b0) begin bad++; $display("FAIL rx_wait%0d: got ready=%0b pop=%0b want 0/0", c, bus.hreadyout, rx_ready); end
        end else begin
          total++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin bad++; $display("FAIL rx_done: got ready=%0b resp=%0b want 1/0", bus.hreadyout, bus.hresp); end
          total++; if (bus.hrdata !== val) begin bad++; $display("FAIL rx_data: got %h want %h", bus.hrdata, val); end
          total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_pop: got %0b want 1", rx_ready); end
        end
        @(posedge Hclk); #1;
      end
      rx_valid = 1'b0;
      @(negedge Hclk);
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_pop_once: got %0b want 0", rx_ready); end
      total++; if (bus.hrdata !== val) begin bad++; $display("FAIL rx_hold: got %h want %h", bus.hrdata, val); end
      @(posedge Hclk); #1;
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [5];
    bit          ew [5];
    logic [2:0]  es [5];
    logic [31:0] rd, wv;
    int w; bit ef, rl, to;
    ea = '{32'h8, 32'hC, 32'h0, 32'h2, 32'h4};
    ew = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    es = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010};
    tx_ready = 1'b0;
    wv = $urandom;
    ahb_xfer(32'h8, 1'b1, 3'b010, wv, rd, w, ef, rl, to);
    ctrl_m = wv;
    for (int i = 0; i < 2; i++) begin
      wv = $urandom;
      ahb_xfer(32'h0, 1'b1, 3'b010, wv, rd, w, ef, rl, to);
      txq.push_back(wv);
    end
    for (int i = 0; i < 5; i++) begin
      ahb_xfer(ea[i], ew[i], es[i], ~ctrl_m, rd, w, ef, rl, to);
      total++; if (to || w != 1 || !ef || !rl) begin bad++; $display("FAIL err%0d_resp: got to=%0b waits=%0d first=%0b last=%0b want 0/1/1/1", i, to, w, ef, rl); end
      total++; if (ctrl !== ctrl_m) begin bad++; $display("FAIL err%0d_ctrl: got %h want %h", i, ctrl, ctrl_m); end
      total++; if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin bad++; $display("FAIL err%0d_fifo: got %0b/%h want 1/%h", i, tx_valid, tx_data, txq[0]); end
    end
    rx_valid = 1'b1; rx_data = $urandom;
    ahb_xfer(32'hC, 1'b0, 3'b010, '0, rd, w, ef, rl, to);
    total++; if (rd !== (32'h8000 | 32'(txq.size()))) begin bad++; $display("FAIL err_status: got %h want %h", rd, 32'h8000 | 32'(txq.size())); end
    rx_valid = 1'b0;
    drain_check();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, wv;
    int w; bit ef, rl, to;
    wv = 32'h5A5A_0001 | $urandom;
    ahb_xfer(32'h8, 1'b1, 3'b010, wv, rd, w, ef, rl, to);
    tx_ready = 1'b0;
    for (int i = 0; i < TXF_DEPTH; i++) ahb_xfer(32'h0, 1'b1, 3'b010, $urandom, rd, w, ef, rl, to);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h0; bus.hwrite = 1'b1; bus.hsize = 3'b010;
    @(posedge Hclk); #1;
    bus_idle();
    bus.hwdata = $urandom;
    @(negedge Hclk);
    total++; if (bus.hreadyout !== 1'b0) begin bad++; $display("FAIL mid_stall: got %0b want 0", bus.hreadyout); end
    #2 Hreset = 1'b1;
    #1;
    total++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin bad++; $display("FAIL mid_rst_bus: got %0b/%0b want 1/0", bus.hreadyout, bus.hresp); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_tx: got %0b want 0", tx_valid); end
    total++; if (ctrl !== CTRL_RST) begin bad++; $display("FAIL mid_rst_ctrl: got %h want %h", ctrl, CTRL_RST); end
    txq.delete();
    ctrl_m = CTRL_RST;
    @(posedge Hclk); @(posedge Hclk); #1;
    Hreset = 1'b0;
    @(negedge Hclk);
    total++; if (bus.hreadyout !== 1'b1 || tx_valid !== 1'b0) begin bad++; $display("FAIL mid_after: got %0b/%0b want 1/0", bus.hreadyout, tx_valid); end
    @(posedge Hclk); #1;
  endtask

  task automatic test_timeout();
    int first_err, first_ready;
    bit rx_pulse;
    logic [31:0] val;
    first_err = -1; first_ready = -1; rx_pulse = 1'b0;
    rx_valid = 1'b0;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h4; bus.hwrite = 1'b0; bus.hsize = 3'b010;
    @(posedge Hclk); #1;
    bus_idle();
    for (int c = 0; c <= 100; c++) begin
      @(negedge Hclk);
      if (bus.hresp && first_err < 0) first_err = c;
      if (bus.hreadyout && first_ready < 0) first_ready = c;
      rx_pulse |= rx_ready;
      @(posedge Hclk); #1;
    end
    total++; if (rx_pulse !== 1'b0) begin bad++; $display("FAIL to_no_pop: got %0b want 0", rx_pulse); end
`ifdef AHB_WAIT_TIMEOUT_EN
    total++; if (first_err != MAX_WAIT) begin bad++; $display("FAIL to_err_cycle: got %0d want %0d", first_err, MAX_WAIT); end
    total++; if (first_ready != MAX_WAIT + 1) begin bad++; $display("FAIL to_ready_cycle: got %0d want %0d", first_ready, MAX_WAIT + 1); end
`else
    total++; if (first_err != -1 || first_ready != -1) begin bad++; $display("FAIL to_still_wait: got err=%0d ready=%0d want -1/-1", first_err, first_ready); end
    val = $urandom;
    rx_valid = 1'b1; rx_data = val;
    @(negedge Hclk);
    total++; if (bus.hreadyout !== 1'b1 || bus.hrdata !== val || rx_ready !== 1'b1) begin bad++; $display("FAIL to_late_done: got %0b/%h/%0b want 1/%h/1", bus.hreadyout, bus.hrdata, rx_ready, val); end
    @(posedge Hclk); #1;
    rx_valid = 1'b0;
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ctrl();
    test_tx_fill();
    test_back_to_back();
    test_rx_wait();
    test_errors();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
